// File: rtl/axi_pkg.sv
// axi_pkg: burst/response encodings, slave FSM states and request validity check
// shared by the burst RAM and its bench.
package axi_pkg;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;
    // Only 4-byte beats with FIXED or INCR bursts are served; WRAP and reserved burst types are rejected.
    function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
        return size != 3'b010 || burst >= WRAP;
    endfunction
endpackage

// File: rtl/axi_ram_array.sv
// axi_ram_array: single-port byte-enabled word array with a registered read port.
// The read register only updates when enabled, so it holds data under back-pressure.
module axi_ram_array #(
    parameter int MEM_WORDS = 1024,
    parameter int IW = $clog2(MEM_WORDS)
)(
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [IW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++)
                if (i_we[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            r_rdata <= r_mem[i_idx];
        end
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_burst_ram.sv
// axi_burst_ram: AXI4 slave RAM serving one write or read INCR/FIXED burst at a time.
// Simultaneous AW and AR in IDLE are resolved write-first so write-backs precede refills.
module axi_burst_ram
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter int MEM_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     axi_awid,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [ID_WIDTH-1:0]     axi_arid,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]              axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [ID_WIDTH-1:0]     axi_rid,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic                    axi_rvalid,
    input  logic                    axi_rready
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);
    state_t r_state, w_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [ADDR_WIDTH:0] r_addr, w_addr, w_off, w_addr_nxt;
    logic [7:0] r_len, r_cnt;
    logic [1:0] r_burst, w_burst;
    logic r_err, r_rvalid, r_rlast, r_rbad;
    logic w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_last_beat, w_in_range, w_en;
    logic [3:0] w_we;
    logic [IW-1:0] w_idx;
    logic [31:0] w_arr_rdata;
    // In IDLE the array is addressed straight from AR so the first beat is ready one cycle later.
    // The address keeps a carry bit so an INCR burst running past the top never wraps back into range.
    assign w_addr = (r_state == IDLE) ? {1'b0, axi_araddr} : r_addr;
    assign w_burst = (r_state == IDLE) ? axi_arburst : r_burst;
    assign w_addr_nxt = (w_burst == INCR) ? w_addr + (ADDR_WIDTH + 1)'(4) : w_addr;
    assign w_off = w_addr - LO;
    assign w_in_range = w_off < SPAN;
    assign w_idx = IW'(w_off >> 2);
    assign w_aw_hs = r_state == IDLE && axi_awvalid;
    assign w_ar_hs = r_state == IDLE && !axi_awvalid && axi_arvalid;
    assign w_w_hs = r_state == W_DATA && axi_wvalid;
    assign w_r_hs = r_rvalid && axi_rready;
    assign w_last_beat = r_cnt == r_len;
    assign axi_bid = r_id;
    assign axi_rid = r_id;
    assign axi_bresp = (r_state == W_RESP && r_err) ? SLVERR : OKAY;
    assign axi_rvalid = r_rvalid;
    assign axi_rlast = r_rlast;
    assign axi_rresp = (r_rvalid && r_rbad) ? SLVERR : OKAY;
    assign axi_rdata = (r_rvalid && !r_rbad) ? w_arr_rdata : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        axi_awready = 1'b0;
        axi_arready = 1'b0;
        axi_wready = 1'b0;
        axi_bvalid = 1'b0;
        w_en = 1'b0;
        w_we = '0;
        case (r_state)
            IDLE: begin
                axi_awready = 1'b1;
                axi_arready = !axi_awvalid;
                if (axi_awvalid) w_next = W_DATA;
                else if (axi_arvalid) begin
                    w_next = R_DATA;
                    w_en = w_in_range;
                end
            end
            W_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    w_en = 1'b1;
                    w_we = (!r_err && w_in_range) ? axi_wstrb : '0;
                    if (w_last_beat) w_next = W_RESP;
                end
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) w_next = IDLE;
            end
            R_DATA: begin
                if (w_r_hs && r_rlast) w_next = IDLE;
                else if (w_r_hs) w_en = w_in_range;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id <= '0;
            r_addr <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_burst <= FIXED;
            r_err <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast <= 1'b0;
            r_rbad <= 1'b0;
        end else if (w_aw_hs) begin
            r_id <= axi_awid;
            r_addr <= {1'b0, axi_awaddr};
            r_len <= axi_awlen;
            r_burst <= axi_awburst;
            r_cnt <= '0;
            r_err <= bad_req(axi_awsize, axi_awburst);
        end else if (w_ar_hs) begin
            r_id <= axi_arid;
            r_addr <= w_addr_nxt;
            r_len <= axi_arlen;
            r_burst <= axi_arburst;
            r_cnt <= '0;
            r_err <= bad_req(axi_arsize, axi_arburst);
            r_rvalid <= 1'b1;
            r_rlast <= axi_arlen == 8'd0;
            r_rbad <= bad_req(axi_arsize, axi_arburst) || !w_in_range;
        end else if (w_w_hs) begin
            r_addr <= w_addr_nxt;
            r_cnt <= r_cnt + 8'd1;
            if (!w_in_range || w_last_beat != axi_wlast) r_err <= 1'b1;
        end else if (w_r_hs && r_rlast) begin
            r_rvalid <= 1'b0;
            r_rlast <= 1'b0;
        end else if (w_r_hs) begin
            r_addr <= w_addr_nxt;
            r_cnt <= r_cnt + 8'd1;
            r_rlast <= r_cnt + 8'd1 == r_len;
            r_rbad <= r_err || !w_in_range;
        end
    end
    axi_ram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
        .clk(clk),
        .i_en(w_en),
        .i_we(w_we),
        .i_idx(w_idx),
        .i_wdata(axi_wdata),
        .o_rdata(w_arr_rdata)
    );
endmodule

// File: tb/tb_axi_burst_ram.sv
// tb_axi_burst_ram: table of single-word strobe writes plus hand-built burst, arbitration,
// back-pressure, error and reset sequences; read beats are checked against a queue of expected beats.
module tb_axi_burst_ram;
    import axi_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] axi_awid = '0, axi_arid = '0, axi_bid, axi_rid;
    logic [31:0] axi_awaddr = '0, axi_araddr = '0, axi_wdata = '0, axi_rdata;
    logic [7:0] axi_awlen = '0, axi_arlen = '0;
    logic [2:0] axi_awsize = 3'd2, axi_arsize = 3'd2;
    logic [1:0] axi_awburst = INCR, axi_arburst = INCR, axi_bresp, axi_rresp;
    logic [3:0] axi_wstrb = '0;
    logic axi_awvalid = 0, axi_wlast = 0, axi_wvalid = 0, axi_bready = 0, axi_arvalid = 0, axi_rready = 0;
    logic axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rlast, axi_rvalid;
    typedef struct packed {logic [31:0] d; logic [1:0] r; logic l;} rexp_t;
    typedef struct {logic [31:0] addr; logic [31:0] pre; logic [31:0] data; logic [3:0] strb; logic [31:0] exp;} vec_t;
    rexp_t q[$];
    vec_t tbl[6];
    logic [31:0] mdl[1024];
    logic [31:0] wd[256];
    logic [3:0] ws[256];
    logic wl[256];
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    axi_burst_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );
    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction
    task automatic fill(input int len, input logic [31:0] base);
        for (int i = 0; i <= len; i++) begin
            wd[i] = base + 32'(i);
            ws[i] = 4'hF;
            wl[i] = i == len;
        end
    endtask
    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [2:0] size, input logic [1:0] eresp, input logic chk_ar);
        int g;
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awsize = size; axi_awvalid = 1;
        #1;
        g = 0;
        while (!axi_awready && g < 50) begin @(negedge clk); #1; g++; end
        check("awready", 32'(axi_awready), 32'd1);
        if (chk_ar) check("arready_during_aw", 32'(axi_arready), 32'd0);
        @(negedge clk);
        axi_awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            axi_wdata = wd[i]; axi_wstrb = ws[i]; axi_wlast = wl[i]; axi_wvalid = 1;
            #1;
            g = 0;
            while (!axi_wready && g < 50) begin @(negedge clk); #1; g++; end
            if (i == 0 || !axi_wready) check("wready", 32'(axi_wready), 32'd1);
            if (chk_ar) check("arready_during_w", 32'(axi_arready), 32'd0);
            @(negedge clk);
        end
        axi_wvalid = 0; axi_wlast = 0;
        #1;
        g = 0;
        while (!axi_bvalid && g < 50) begin @(negedge clk); #1; g++; end
        check("bvalid", 32'(axi_bvalid), 32'd1);
        check("bresp", 32'(axi_bresp), 32'(eresp));
        check("bid", 32'(axi_bid), 32'(id));
        if (chk_ar) check("arready_during_b", 32'(axi_arready), 32'd0);
        axi_bready = 1;
        @(negedge clk);
        axi_bready = 0;
        #1;
        check("awready_after_b", 32'(axi_awready), 32'd1);
        check("bvalid_after_b", 32'(axi_bvalid), 32'd0);
    endtask
    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input int bp_beat, input int bp_n, input int stop);
        int g, beat;
        logic [31:0] hd;
        logic [1:0] hr;
        logic hl;
        rexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            longint a = (burst == INCR) ? longint'(addr) + 4 * i : longint'(addr);
            if (burst >= WRAP || a >= 4096) q.push_back('{32'h0, SLVERR, i == int'(len)});
            else q.push_back('{mdl[int'(a >> 2)], OKAY, i == int'(len)});
        end
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arsize = 3'd2; axi_arvalid = 1;
        #1;
        g = 0;
        while (!axi_arready && g < 50) begin @(negedge clk); #1; g++; end
        check("arready", 32'(axi_arready), 32'd1);
        check("rvalid_before_ar", 32'(axi_rvalid), 32'd0);
        @(negedge clk);
        axi_arvalid = 0;
        #1;
        check("rvalid_latency", 32'(axi_rvalid), 32'd1);
        beat = 0; g = 0;
        while (beat <= int'(len) && beat < stop && g < 2000) begin
            if (axi_rvalid) begin
                if (beat == bp_beat && bp_n > 0) begin
                    axi_rready = 0;
                    hd = axi_rdata; hr = axi_rresp; hl = axi_rlast;
                    repeat (bp_n) begin
                        @(negedge clk); #1;
                        check("hold_rvalid", 32'(axi_rvalid), 32'd1);
                        check("hold_rdata", axi_rdata, hd);
                        check("hold_rresp", 32'(axi_rresp), 32'(hr));
                        check("hold_rlast", 32'(axi_rlast), 32'(hl));
                    end
                end
                axi_rready = 1;
                if (q.size() == 0) check("queue_empty", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check($sformatf("rdata[%0d]", beat), axi_rdata, e.d);
                    check($sformatf("rresp[%0d]", beat), 32'(axi_rresp), 32'(e.r));
                    check($sformatf("rlast[%0d]", beat), 32'(axi_rlast), 32'(e.l));
                    check("rid", 32'(axi_rid), 32'(id));
                end
                beat++;
            end
            @(negedge clk); #1;
            g++;
        end
        axi_rready = 0;
        if (stop > int'(len)) begin
            check("beats", 32'(beat), 32'(len) + 32'd1);
            check("rvalid_end", 32'(axi_rvalid), 32'd0);
        end
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        tbl[0] = '{32'h010, 32'hFFFF_FFFF, 32'h1234_5678, 4'b0101, 32'hFF34_FF78};
        tbl[1] = '{32'h014, 32'h0000_0000, 32'hAABB_CCDD, 4'b1010, 32'hAA00_CC00};
        tbl[2] = '{32'h018, 32'h1111_1111, 32'h0000_0000, 4'b0001, 32'h1111_1100};
        tbl[3] = '{32'h021, 32'h0000_0000, 32'h5A5A_5A5A, 4'b1100, 32'h5A5A_0000};
        tbl[4] = '{32'hFFC, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
        tbl[5] = '{32'h000, 32'hCCCC_CCCC, 32'h0000_0000, 4'b0000, 32'hCCCC_CCCC};
        repeat (2) @(negedge clk);
        #1;
        check("rst_awready", 32'(axi_awready), 32'd1);
        check("rst_arready", 32'(axi_arready), 32'd1);
        check("rst_wready", 32'(axi_wready), 32'd0);
        check("rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("rst_rlast", 32'(axi_rlast), 32'd0);
        check("rst_rdata", axi_rdata, 32'd0);
        check("rst_resp", {28'd0, axi_bresp, axi_rresp}, 32'd0);
        check("rst_ids", {24'd0, axi_bid, axi_rid}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            fill(0, tbl[k].pre);
            wr(4'd1, tbl[k].addr, 8'd0, INCR, 3'd2, OKAY, 1'b0);
            wd[0] = tbl[k].data; ws[0] = tbl[k].strb;
            wr(4'd2, tbl[k].addr, 8'd0, INCR, 3'd2, OKAY, 1'b0);
            mdl[int'(tbl[k].addr >> 2)] = tbl[k].exp;
            rd(4'd3, tbl[k].addr, 8'd0, INCR, -1, 0, 999);
        end
        fill(7, 32'hA0);
        wr(4'd3, 32'h100, 8'd7, INCR, 3'd2, OKAY, 1'b0);
        for (int i = 0; i < 8; i++) mdl[64 + i] = 32'hA0 + 32'(i);
        rd(4'd5, 32'h100, 8'd7, INCR, -1, 0, 999);
        rd(4'd6, 32'h100, 8'd3, INCR, 1, 3, 999);
        rd(4'd7, 32'h104, 8'd2, FIXED, -1, 0, 999);
        axi_arid = 4'd9; axi_araddr = 32'h200; axi_arlen = 8'd0; axi_arburst = INCR; axi_arvalid = 1;
        fill(0, 32'hCAFE_F00D);
        wr(4'd8, 32'h200, 8'd0, INCR, 3'd2, OKAY, 1'b1);
        mdl[128] = 32'hCAFE_F00D;
        rd(4'd9, 32'h200, 8'd0, INCR, -1, 0, 999);
        fill(1, 32'h1111_1111);
        wd[1] = 32'h2222_2222;
        wr(4'd1, 32'hFFC, 8'd1, INCR, 3'd2, SLVERR, 1'b0);
        mdl[1023] = 32'h1111_1111;
        rd(4'd2, 32'hFFC, 8'd1, INCR, -1, 0, 999);
        rd(4'd2, 32'h000, 8'd0, INCR, -1, 0, 999);
        fill(3, 32'h3000_0000);
        wr(4'd4, 32'h300, 8'd3, INCR, 3'd2, OKAY, 1'b0);
        for (int i = 0; i < 4; i++) mdl[192 + i] = 32'h3000_0000 + 32'(i);
        fill(3, 32'hBAD0_0000);
        wr(4'd4, 32'h300, 8'd3, WRAP, 3'd2, SLVERR, 1'b0);
        rd(4'd4, 32'h300, 8'd3, INCR, -1, 0, 999);
        fill(3, 32'hBAD1_0000);
        ws[0] = 4'h0; wl[0] = 1'b1;
        wr(4'd5, 32'h300, 8'd3, INCR, 3'd2, SLVERR, 1'b0);
        rd(4'd5, 32'h300, 8'd3, INCR, -1, 0, 999);
        fill(0, 32'hBAD2_0000);
        wr(4'd6, 32'h30C, 8'd0, INCR, 3'd3, SLVERR, 1'b0);
        rd(4'd6, 32'h30C, 8'd0, INCR, -1, 0, 999);
        rd(4'd7, 32'h100, 8'd1, WRAP, -1, 0, 999);
        rd(4'd8, 32'h100, 8'd7, INCR, -1, 0, 2);
        rst_n = 0;
        #1;
        check("midrst_rvalid", 32'(axi_rvalid), 32'd0);
        check("midrst_rlast", 32'(axi_rlast), 32'd0);
        check("midrst_rdata", axi_rdata, 32'd0);
        check("midrst_awready", 32'(axi_awready), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        rd(4'd9, 32'h100, 8'd7, INCR, -1, 0, 999);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_burst_ram.md
Name: axi_burst_ram

Overview:
- AXI4 slave memory model that sits directly downstream of holy_cache's AXI master port.
- It absorbs cache line write-backs and serves line refills as INCR bursts.
- It is synthesizable, so the same block serves as the cocotb bench memory and as on-chip RAM on FPGA.
- It handles one transaction at a time: a single write or a single read burst in flight.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width. Only 32 is supported.
- ID_WIDTH, 4, AXI ID width.
- MEM_WORDS, 1024, depth in 32-bit words. Must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- axi_awid  in  ID_WIDTH  write ID
- axi_awaddr  in  ADDR_WIDTH  write start byte address
- axi_awlen  in  8  write beats minus 1
- axi_awsize  in  3  write beat size; must be 3'b010
- axi_awburst  in  2  write burst type
- axi_awvalid  in  1  AW valid
- axi_awready  out  1  AW ready
- axi_wdata  in  32  write data
- axi_wstrb  in  4  write byte strobes
- axi_wlast  in  1  last write beat
- axi_wvalid  in  1  W valid
- axi_wready  out  1  W ready
- axi_bid  out  ID_WIDTH  response ID
- axi_bresp  out  2  write response
- axi_bvalid  out  1  B valid
- axi_bready  in  1  B ready
- axi_arid  in  ID_WIDTH  read ID
- axi_araddr  in  ADDR_WIDTH  read start byte address
- axi_arlen  in  8  read beats minus 1
- axi_arsize  in  3  read beat size; must be 3'b010
- axi_arburst  in  2  read burst type
- axi_arvalid  in  1  AR valid
- axi_arready  out  1  AR ready
- axi_rid  out  ID_WIDTH  read ID
- axi_rdata  out  32  read data
- axi_rresp  out  2  read response
- axi_rlast  out  1  last read beat
- axi_rvalid  out  1  R valid
- axi_rready  in  1  R ready

Behaviour:
- Reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - State goes to IDLE; all counters and latched fields clear.
  - bvalid, rvalid, rlast and wready are 0; bresp, rresp, rdata, bid and rid are 0.
  - awready and arready follow the IDLE decode shown below. Memory contents are not reset.
- States: IDLE, W_DATA, W_RESP, R_DATA.
- IDLE:
  - awready = 1.
  - arready = !awvalid, so a simultaneous AW and AR is resolved write-first. This keeps write-back ahead of refill.
  - AW handshake:
    - Latch awid, the word address, awlen and awburst; clear the beat counter and err.
    - err = 1 if awsize != 2 or awburst is neither FIXED nor INCR.
    - Go to W_DATA.
  - AR handshake:
    - Latch the same fields from the AR channel.
    - Go to R_DATA, with the first beat presented on the next cycle.
- W_DATA:
  - wready = 1.
  - On each W handshake, write bytes where wstrb[i] = 1, provided err = 0 and the address is in range.
  - Out-of-range beats are dropped and set err.
  - The address increments by one word for INCR and holds for FIXED. The beat counter increments.
  - On the beat where counter == len, go to W_RESP.
  - wlast asserted on any other beat, or not asserted on that beat, sets err.
- W_RESP:
  - bvalid = 1, bid = the latched ID, bresp = err ? SLVERR : OKAY.
  - On bready, go to IDLE. awready is 1 on the following cycle.
- R_DATA:
  - rvalid is registered and rdata is registered from the array.
  - First beat: rvalid rises exactly 1 cycle after the AR handshake.
  - Under back-pressure (rready = 0), rdata, rresp and rlast hold stable.
  - On a handshake with more beats left, the next beat is valid on the next cycle. Sustained throughput is 1 beat per cycle.
  - rlast = 1 only on beat len.
  - An out-of-range or err beat returns rdata = 0 and rresp = SLVERR. Other beats return OKAY.
  - After the rlast handshake, rvalid drops and the state goes to IDLE.
- Address range:
  - In range means BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS.
  - The index is (addr - BASE_ADDR) >> 2. The low 2 address bits are ignored.
  - INCR wrap past the top of the array is out of range. It does not wrap to 0.
- Length: awlen and arlen are 0..255 (1..256 beats). len = 0 is a single beat, with rlast on the first beat.
- Reset mid-burst: the transaction is aborted and outputs return to their reset values. Writes already performed persist.
- Not supported: no outstanding-transaction queue, no interleaving, no exclusive access. Only one burst is in flight.

Decomposition:
- axi_pkg holds the shared definitions:
  - burst-type constants FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  - response constants OKAY = 2'b00, SLVERR = 2'b10;
  - the state enum.
- One sub-module, axi_ram_array: a single-port, byte-enabled, synchronous-read array of MEM_WORDS x 32.
  - Inputs: en, we[3:0], idx, wdata. Output: rdata.
  - Only W_DATA and R_DATA drive it, so a single port suffices.

Test Plan:
- Write then read:
  - Stimulus: INCR awlen=7 at 0x100, data 0xA0..0xA7, wstrb=F; then INCR arlen=7 at 0x100.
  - Response: bresp=OKAY; eight beats return 0xA0..0xA7 in order, rlast only on beat 7, first rvalid 1 cycle after AR handshake.
- Byte strobes:
  - Stimulus: write 0xFFFFFFFF to 0x10, then a single beat 0x12345678 with wstrb=4'b0101, then read 0x10.
  - Response: read returns 0xFF34FF78.
- Simultaneous requests:
  - Stimulus: awvalid and arvalid asserted in the same IDLE cycle.
  - Response: AW accepted and arready=0; AR is accepted only after the bready handshake; the read returns the newly written data.
- Read back-pressure:
  - Stimulus: arlen=3 with rready low for 3 cycles on beat 1.
  - Response: rdata, rresp and rlast hold stable; the burst completes with 4 handshakes and no beat is lost or duplicated.
- Errors:
  - Stimulus: write at BASE_ADDR + 4*MEM_WORDS - 4 with awlen=1; separately, awburst=WRAP; separately, wlast early on beat 0 of awlen=3.
  - Response: all three get bresp=SLVERR; the in-range first beat of the first case is written, no other memory word changes.
- Reset mid-burst:
  - Stimulus: rst_n low during beat 2 of an arlen=7 read, then released.
  - Response: rvalid=0 immediately; state is IDLE with awready=1; a new read of the same address returns the original data.
